alu_bist: RTL and testbench
===========================

Name: alu_bist

Overview:
- Self-checking stimulus generator and result checker for the 2-stage pipelined 8-bit ALU (ports data_a_i, data_b_i, inst_i, data_o).
- Drives operand/instruction vectors into the ALU, models the expected result internally and delays it by the ALU latency.
- Compares against data_o and reports pass/fail, error count and the first mismatch.
- Sits beside the ALU as an on-chip BIST master; it is the initiator, and the ALU is the responder.

Parameters:
- N, 32, operand sweep size for two-operand instructions (A and B each 0..N-1); also sets the one-operand sweep range -N/2..N/2-1.
- LAT, 2, ALU latency in cycles from data_a/b/inst applied to data_o valid.

Ports:
- clk_p_i  input  1  clock, rising edge.
- reset_n_i  input  1  asynchronous active-low reset.
- start_i  input  1  one-cycle pulse that starts a run; sampled in IDLE and DONE only.
- test_sel_i  input  3  000..110 runs that instruction only; 111 runs all seven in order 000..110. Latched at start.
- data_a_o  output  8  to ALU data_a_i.
- data_b_o  output  8  to ALU data_b_i.
- inst_o  output  3  to ALU inst_i.
- data_i  input  16  from ALU data_o.
- busy_o  output  1  high while the run is in progress.
- done_o  output  1  high in DONE until the next start or reset.
- pass_o  output  1  valid when done_o=1; high iff err_cnt_o==0.
- err_cnt_o  output  16  mismatch count, saturating at 0xFFFF.
- fail_inst_o  output  3  instruction of the first mismatch.
- fail_exp_o  output  16  expected value of the first mismatch.
- fail_got_o  output  16  received value of the first mismatch.

Behaviour:
- Reset (async, reset_n_i=0): state IDLE; all outputs 0; pipeline valid bits cleared.
- States and transitions:
  - IDLE, on start → RUN.
  - RUN, after the last vector is issued → DRAIN.
  - DRAIN, after LAT cycles → DONE.
  - DONE, on start → RUN, with the counters and capture registers cleared.
- start_i in RUN or DRAIN is ignored.
- Each RUN cycle issues exactly one vector on data_a_o/data_b_o/inst_o, registered.
- Two-operand instructions (000, 001, 010, 100, 110): A outer loop 0..N-1, B inner loop 0..N-1. N*N vectors.
- One-operand instructions (011, 101): A sweeps -N/2..N/2-1 in 8-bit two's complement (0xF0..0x0F for N=32); B=0. N vectors.
- Instructions change back-to-back with no bubble; the pipeline is not flushed between instructions.
- Expected results, 16-bit, computed from the issued vector:
  - 000: A+B.
  - 001: (B-A) mod 2^16.
  - 010: B*A.
  - 011: {8'h00, ~A}.
  - 100: {8'h00, A^B}.
  - 101: {8'h00, |A|}, where A is signed 8-bit and |-128| = 0x80.
  - 110: bits [16:1] of the 17-bit signed value B-A (e.g. B=0, A=1 → 0xFFFF).
- The expected value plus a valid bit enter a LAT-deep shift register on issue.
- Compare on the cycle the valid bit exits, i.e. vector issued in cycle k is compared with data_i in cycle k+LAT.
- The first LAT issued vectors after each start are compared with valid=0 (pipeline fill, masked). All later vectors are checked, including across instruction boundaries and during DRAIN.
- On mismatch: err_cnt_o increments, saturating. On the first mismatch only, fail_inst_o/fail_exp_o/fail_got_o are captured.
- busy_o is high for exactly (vector count + LAT) cycles.
- done_o and pass_o rise together on the cycle after DRAIN ends.
- data_a_o/data_b_o/inst_o hold their last value outside RUN.
- Reset mid-run aborts immediately to IDLE with all outputs 0; no partial result is retained.

Test Plan:
- Correct ALU model, test_sel=111, start pulse:
  - 5*1024+2*32 = 5184 vectors; busy_o high 5186 cycles.
  - done_o=1, pass_o=1, err_cnt_o=0.
- test_sel=011, correct ALU:
  - data_a_o sequence 0xF0..0x0F.
  - Expected for A=0xF0 is 0x000F.
  - done after 34 cycles, pass_o=1.
- test_sel=110, ALU model forcing data_o=0 for inst 110:
  - First failure at A=0,B=2: fail_inst_o=110, fail_exp_o=0x0001, fail_got_o=0x0000.
  - err_cnt_o equals the count of nonzero expected values.
- test_sel=010, ALU model with bit 0 stuck at 0:
  - err_cnt_o = 256 (odd products).
  - First failure A=1,B=1, exp 0x0001.
- ALU with latency 3 (mismatched) on test_sel=000:
  - pass_o=0, err_cnt_o>0.
- Reset asserted at cycle 100 of RUN:
  - All outputs 0 immediately, state IDLE.
  - A new start completes a full clean run with pass_o=1.
- start_i pulsed during RUN: ignored; the vector count is unchanged.

Source files
------------

// File: rtl/alu_bist_if.sv
// ALU stimulus/response bus between the BIST master and the ALU under test.
//   data_a_o / data_b_o : operands driven by the master
//   inst_o              : instruction driven by the master
//   data_i              : 16-bit ALU result returned by the responder
interface alu_bist_if;
  logic [7:0]  data_a_o;
  logic [7:0]  data_b_o;
  logic [2:0]  inst_o;
  logic [15:0] data_i;

  modport master (output data_a_o, output data_b_o, output inst_o, input data_i);
  modport slave  (input data_a_o, input data_b_o, input inst_o, output data_i);
endinterface

// File: rtl/alu_bist.sv
// On-chip BIST master for the 2-stage pipelined 8-bit ALU. Sweeps operand
// vectors for the selected instruction(s), models the expected result, delays
// it by the ALU latency and compares against the returned data.
// Ports:
//   clk_p_i, reset_n_i   : clock (rising edge), async active-low reset
//   start_i              : start pulse, honoured in IDLE/DONE only
//   test_sel_i           : 0..6 single instruction, 7 all instructions
//   alu                  : ALU bus (operands/instruction out, result in)
//   busy_o, done_o       : run in progress / run finished
//   pass_o, err_cnt_o    : verdict and saturating mismatch count
//   fail_inst/exp/got_o  : details of the first mismatch
module alu_bist #(
  parameter int N   = 32,
  parameter int LAT = 2
) (
  input  logic        clk_p_i,
  input  logic        reset_n_i,
  input  logic        start_i,
  input  logic [2:0]  test_sel_i,
  alu_bist_if.master  alu,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [15:0] err_cnt_o,
  output logic [2:0]  fail_inst_o,
  output logic [15:0] fail_exp_o,
  output logic [15:0] fail_got_o
);

  localparam int              CW    = $clog2(N);
  localparam int              FW    = $clog2(LAT + 1);
  localparam logic [CW-1:0]   LAST  = CW'(N - 1);
  localparam logic [7:0]      HALF  = 8'(N / 2);
  localparam logic [FW-1:0]   LATV  = FW'(LAT);
  localparam logic [FW-1:0]   DLAST = FW'(LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic              all_q, all_d;
  logic [2:0]        inst_q, inst_d;
  logic [CW-1:0]     a_q, a_d, b_q, b_d;
  logic [7:0]        data_a_q, data_a_d, data_b_q, data_b_d;
  logic [FW-1:0]     fill_q, fill_d, drain_q, drain_d;
  logic [15:0]       exp_pipe_q [LAT];
  logic [15:0]       exp_pipe_d [LAT];
  logic [LAT-1:0]    vld_pipe_q, vld_pipe_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [15:0]       err_q, err_d, fexp_q, fexp_d, fgot_q, fgot_d;
  logic [2:0]        finst_q, finst_d;

  // Working variables of the next-state logic.
  logic              last_inst, last_vec;
  logic [CW-1:0]     a_n, b_n;
  logic [2:0]        inst_n, sel_inst;

  function automatic logic is_one_op(input logic [2:0] op);
    return (op == 3'b011) || (op == 3'b101);
  endfunction

  // One-operand sweeps are centred on zero in two's complement.
  function automatic logic [7:0] vec_a(input logic [CW-1:0] idx, input logic [2:0] op);
    return is_one_op(op) ? (8'(idx) - HALF) : 8'(idx);
  endfunction

  function automatic logic [15:0] exp_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    logic [16:0] d;
    logic [7:0]  m;
    d = {{9{b[7]}}, b} - {{9{a[7]}}, a};
    m = a[7] ? (8'd0 - a) : a;
    case (op)
      3'b000:  return {8'h00, a} + {8'h00, b};
      3'b001:  return {8'h00, b} - {8'h00, a};
      3'b010:  return {8'h00, b} * {8'h00, a};
      3'b011:  return {8'h00, ~a};
      3'b100:  return {8'h00, a ^ b};
      3'b101:  return {8'h00, m};
      default: return d[16:1];
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    state_d  = state_q;
    all_d    = all_q;
    inst_d   = inst_q;
    a_d      = a_q;
    b_d      = b_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    fill_d   = fill_q;
    drain_d  = drain_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    finst_d  = finst_q;
    fexp_d   = fexp_q;
    fgot_d   = fgot_q;
    a_n      = a_q;
    b_n      = b_q;
    inst_n   = inst_q;
    sel_inst = (test_sel_i == 3'b111) ? 3'b000 : test_sel_i;

    // Stage boundary: issued vector -> expected-value delay line. The first
    // LAT vectors after start meet stale ALU contents and are masked.
    exp_pipe_d[0] = exp_f(data_a_q, data_b_q, inst_q);
    vld_pipe_d[0] = (state_q == RUN) && (fill_q == LATV);
    for (int i = 1; i < LAT; i++) begin
      exp_pipe_d[i] = exp_pipe_q[i-1];
      vld_pipe_d[i] = vld_pipe_q[i-1];
    end
    if ((state_q == RUN) && (fill_q != LATV)) fill_d = fill_q + 1'b1;

    // Stage boundary: delay-line exit, compared with the ALU result.
    if (vld_pipe_q[LAT-1] && (alu.data_i != exp_pipe_q[LAT-1])) begin
      err_d = sat_inc(err_q);
      if (err_q == 16'h0000) begin
        finst_d = inst_n;
        finst_d = alu_inst_at_exit();
        fexp_d  = exp_pipe_q[LAT-1];
        fgot_d  = alu.data_i;
      end
    end

    last_inst = is_one_op(inst_q) ? (a_q == LAST) : ((a_q == LAST) && (b_q == LAST));
    last_vec  = last_inst && (!all_q || (inst_q == 3'b110));

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d  = RUN;
          all_d    = (test_sel_i == 3'b111);
          inst_d   = sel_inst;
          a_d      = '0;
          b_d      = '0;
          data_a_d = vec_a('0, sel_inst);
          data_b_d = 8'h00;
          fill_d   = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          err_d    = 16'h0000;
          finst_d  = 3'b000;
          fexp_d   = 16'h0000;
          fgot_d   = 16'h0000;
        end
      end
      RUN: begin
        if (last_vec) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          if (last_inst) begin
            inst_n = inst_q + 3'd1;
            a_n    = '0;
            b_n    = '0;
          end else if (is_one_op(inst_q) || (b_q == LAST)) begin
            a_n = a_q + 1'b1;
            b_n = '0;
          end else begin
            b_n = b_q + 1'b1;
          end
          inst_d   = inst_n;
          a_d      = a_n;
          b_d      = b_n;
          data_a_d = vec_a(a_n, inst_n);
          data_b_d = is_one_op(inst_n) ? 8'h00 : 8'(b_n);
        end
      end
      default: begin
        if (drain_q == DLAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 16'h0000);
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
    endcase
  end

  // Instruction tag travelling with each expected value, so the first-failure
  // capture reports the instruction of the mismatching vector even across
  // instruction boundaries.
  logic [2:0] inst_pipe_q [LAT];
  logic [2:0] inst_pipe_d [LAT];

  function automatic logic [2:0] alu_inst_at_exit();
    return inst_pipe_q[LAT-1];
  endfunction

  always_comb begin
    inst_pipe_d[0] = inst_q;
    for (int i = 1; i < LAT; i++) inst_pipe_d[i] = inst_pipe_q[i-1];
  end

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      all_q      <= 1'b0;
      inst_q     <= 3'b000;
      a_q        <= '0;
      b_q        <= '0;
      data_a_q   <= 8'h00;
      data_b_q   <= 8'h00;
      fill_q     <= '0;
      drain_q    <= '0;
      vld_pipe_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        exp_pipe_q[i]  <= 16'h0000;
        inst_pipe_q[i] <= 3'b000;
      end
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= 16'h0000;
      finst_q    <= 3'b000;
      fexp_q     <= 16'h0000;
      fgot_q     <= 16'h0000;
    end else begin
      state_q    <= state_d;
      all_q      <= all_d;
      inst_q     <= inst_d;
      a_q        <= a_d;
      b_q        <= b_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      fill_q     <= fill_d;
      drain_q    <= drain_d;
      vld_pipe_q <= vld_pipe_d;
      for (int i = 0; i < LAT; i++) begin
        exp_pipe_q[i]  <= exp_pipe_d[i];
        inst_pipe_q[i] <= inst_pipe_d[i];
      end
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      finst_q    <= finst_d;
      fexp_q     <= fexp_d;
      fgot_q     <= fgot_d;
    end
  end

  assign alu.data_a_o = data_a_q;
  assign alu.data_b_o = data_b_q;
  assign alu.inst_o   = inst_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign err_cnt_o    = err_q;
  assign fail_inst_o  = finst_q;
  assign fail_exp_o   = fexp_q;
  assign fail_got_o   = fgot_q;

endmodule

// File: tb/tb_alu_bist.sv
module tb_alu_bist;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  test_sel = 3'b000;
  logic        busy_o, done_o, pass_o;
  logic [15:0] err_cnt_o, fail_exp_o, fail_got_o;
  logic [2:0]  fail_inst_o;
  int          mode = 0;   // 0 correct, 1 inst 110 forced 0, 2 bit0 stuck 0, 3 latency 3
  int          total = 0;
  int          bad = 0;

  alu_bist_if bus ();

  alu_bist #(.N(32), .LAT(2)) dut (
    .clk_p_i(clk), .reset_n_i(reset_n), .start_i(start), .test_sel_i(test_sel),
    .alu(bus), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .err_cnt_o(err_cnt_o), .fail_inst_o(fail_inst_o),
    .fail_exp_o(fail_exp_o), .fail_got_o(fail_got_o)
  );

  always #5 clk = ~clk;

  // Behavioural reference ALU written with integer arithmetic.
  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
    logic signed [7:0] sa, sb;
    int ia, ib, r;
    sa = a; sb = b; ia = sa; ib = sb;
    case (op)
      3'd0: r = int'(a) + int'(b);
      3'd1: r = int'(b) - int'(a);
      3'd2: r = int'(a) * int'(b);
      3'd3: r = 255 - int'(a);
      3'd4: r = int'(a ^ b);
      3'd5: r = (ia < 0) ? -ia : ia;
      default: r = (ib - ia) >>> 1;
    endcase
    return 16'(r);
  endfunction

  logic [15:0] s1 = '0, s2 = '0, s3 = '0, alu_out;
  logic [2:0]  i1 = '0, i2 = '0, i3 = '0, out_inst;
  always @(posedge clk) begin
    s1 <= alu_ref(bus.data_a_o, bus.data_b_o, bus.inst_o);
    s2 <= s1; s3 <= s2;
    i1 <= bus.inst_o; i2 <= i1; i3 <= i2;
  end
  always_comb begin
    alu_out  = (mode == 3) ? s3 : s2;
    out_inst = (mode == 3) ? i3 : i2;
    if (mode == 1 && out_inst == 3'b110) alu_out = 16'h0000;
    if (mode == 2) alu_out[0] = 1'b0;
  end
  assign bus.data_i = alu_out;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic run(input logic [2:0] sel, input bit extra, output int cyc);
    @(negedge clk); start = 1'b1; test_sel = sel;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (busy_o === 1'b1 && cyc < 20000) begin
      cyc++;
      if (extra && cyc == 50) begin start = 1'b1; test_sel = 3'b011; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  sel;
    int          mode;
    int          busy;
    logic        pass;
    int          err;
    bit          err_any;
    bit          chk_fail;
    logic [2:0]  f_inst;
    logic [15:0] f_exp;
    logic [15:0] f_got;
  } vec_t;

  vec_t tbl [8];
  int   cyc;

  initial begin
    tbl[0] = '{3'd7, 0, 5186, 1'b1, 0,   1'b0, 1'b1, 3'd0, 16'h0000, 16'h0000};
    tbl[1] = '{3'd3, 0, 34,   1'b1, 0,   1'b0, 1'b1, 3'd0, 16'h0000, 16'h0000};
    tbl[2] = '{3'd6, 1, 1026, 1'b0, 961, 1'b0, 1'b1, 3'd6, 16'h0001, 16'h0000};
    tbl[3] = '{3'd2, 2, 1026, 1'b0, 256, 1'b0, 1'b1, 3'd2, 16'h0001, 16'h0000};
    tbl[4] = '{3'd0, 3, 1026, 1'b0, 0,   1'b1, 1'b0, 3'd0, 16'h0000, 16'h0000};
    tbl[5] = '{3'd1, 0, 1026, 1'b1, 0,   1'b0, 1'b1, 3'd0, 16'h0000, 16'h0000};
    tbl[6] = '{3'd5, 0, 34,   1'b1, 0,   1'b0, 1'b1, 3'd0, 16'h0000, 16'h0000};
    tbl[7] = '{3'd4, 0, 1026, 1'b1, 0,   1'b0, 1'b1, 3'd0, 16'h0000, 16'h0000};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_pass", 32'(pass_o), 0);
    chk("rst_err", 32'(err_cnt_o), 0);
    chk("rst_a", 32'(bus.data_a_o), 0);
    chk("rst_inst", 32'(bus.inst_o), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      mode = tbl[i].mode;
      run(tbl[i].sel, 1'b0, cyc);
      chk($sformatf("busy_cycles[%0d]", i), 32'(cyc), 32'(tbl[i].busy));
      chk($sformatf("done[%0d]", i), 32'(done_o), 1);
      chk($sformatf("pass[%0d]", i), 32'(pass_o), 32'(tbl[i].pass));
      if (tbl[i].err_any) chk($sformatf("err_nonzero[%0d]", i), 32'(err_cnt_o != 0), 1);
      else                chk($sformatf("err_cnt[%0d]", i), 32'(err_cnt_o), 32'(tbl[i].err));
      if (tbl[i].chk_fail) begin
        chk($sformatf("fail_inst[%0d]", i), 32'(fail_inst_o), 32'(tbl[i].f_inst));
        chk($sformatf("fail_exp[%0d]", i), 32'(fail_exp_o), 32'(tbl[i].f_exp));
        chk($sformatf("fail_got[%0d]", i), 32'(fail_got_o), 32'(tbl[i].f_got));
      end
    end
    mode = 0;

    // done_o holds in DONE
    repeat (5) @(negedge clk);
    chk("done_hold", 32'(done_o), 1);

    // One-operand sweep: A walks 0xF0..0x0F, B stays 0
    @(negedge clk); start = 1'b1; test_sel = 3'b011;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      logic [7:0] ea;
      ea = 8'hF0 + 8'(i);
      chk($sformatf("sweep_a[%0d]", i), 32'(bus.data_a_o), 32'(ea));
      if (i == 0) begin
        chk("sweep_b", 32'(bus.data_b_o), 0);
        chk("sweep_inst", 32'(bus.inst_o), 3);
        chk("sweep_done_clr", 32'(done_o), 0);
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("sweep_done", 32'(done_o), 1);
    chk("sweep_pass", 32'(pass_o), 1);
    chk("sweep_hold_a", 32'(bus.data_a_o), 32'h0F);

    // Reset in the middle of a full run
    @(negedge clk); start = 1'b1; test_sel = 3'b111;
    @(negedge clk); start = 1'b0;
    repeat (100) @(negedge clk);
    chk("midrun_busy_pre", 32'(busy_o), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrun_busy", 32'(busy_o), 0);
    chk("midrun_a", 32'(bus.data_a_o), 0);
    chk("midrun_b", 32'(bus.data_b_o), 0);
    chk("midrun_done", 32'(done_o), 0);
    chk("midrun_err", 32'(err_cnt_o), 0);
    @(negedge clk); reset_n = 1'b1;
    run(3'd0, 1'b0, cyc);
    chk("after_rst_cycles", 32'(cyc), 1026);
    chk("after_rst_pass", 32'(pass_o), 1);

    // start_i pulsed during RUN is ignored
    run(3'd0, 1'b1, cyc);
    chk("restart_ignored_cycles", 32'(cyc), 1026);
    chk("restart_ignored_pass", 32'(pass_o), 1);
    chk("restart_ignored_inst", 32'(bus.inst_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
